// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the video timing generator.
// Defaults describe 640x480@60 with a 25 MHz-class pixel rate.
package vga_timing_pkg;

    localparam int DEF_PIX_DIV  = 4;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Total positions in one line (or one frame) including blanking
    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First position of the sync window
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // First position after the sync window
    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    // Bits needed to count 0..value-1 (0 for value <= 1)
    function automatic int clog2_int(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

    localparam int DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/pix_ce_div.sv
// Pixel clock-enable divider: one-clk pix_ce pulse every PIX_DIV enabled clocks.
module pix_ce_div
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV = DEF_PIX_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic pix_ce
);

    localparam int DIV_W = (PIX_DIV > 1) ? clog2_int(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic             pix_ce_reg;

    // Count while enabled; the pulse is registered on the clk the count wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg    <= '0;
            pix_ce_reg <= 1'b0;
        end else if (enable) begin
            if (div_reg == DIV_LAST) begin
                div_reg    <= '0;
                pix_ce_reg <= 1'b1;
            end else begin
                div_reg    <= div_reg + DIV_W'(1);
                pix_ce_reg <= 1'b0;
            end
        end else begin
            pix_ce_reg <= 1'b0;
        end
    end

    assign pix_ce = pix_ce_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: pixel divider, h/v counters, sync/de
// decode and linear frame-buffer address, all registered and position-aligned.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COL_W    = 10,
    parameter int ROW_W    = 10,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              pix_ce,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              line_start,
    output logic              frame_start,
    output logic [ADDR_W-1:0] addr
);

    localparam int H_TOTAL      = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START     = sync_start(H_ACTIVE, H_FP);
    localparam int HS_END       = sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam int VS_START     = sync_start(V_ACTIVE, V_FP);
    localparam int VS_END       = sync_end(V_ACTIVE, V_FP, V_SYNC);
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_TOTAL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_TOTAL - 1);

    // Reject configurations whose counters or address cannot hold their range
    generate
        if (PIX_DIV < 1) begin : g_bad_div
            $error("PIX_DIV must be at least 1");
        end
        if ((H_TOTAL - 1) >= (1 << COL_W)) begin : g_bad_col_w
            $error("COL_W too narrow for H_TOTAL-1");
        end
        if ((V_TOTAL - 1) >= (1 << ROW_W)) begin : g_bad_row_w
            $error("ROW_W too narrow for V_TOTAL-1");
        end
        if (FRAME_PIXELS >= (1 << ADDR_W)) begin : g_bad_addr_w
            $error("ADDR_W too narrow for H_ACTIVE*V_ACTIVE");
        end
    endgenerate

    logic pix_ce_int;

    pix_ce_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_ce_div (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .pix_ce (pix_ce_int)
    );

    logic              advance;
    logic [COL_W-1:0]  col_reg,   col_next;
    logic [ROW_W-1:0]  row_reg,   row_next;
    logic              de_reg,    de_next;
    logic              hsync_reg, hsync_next;
    logic              vsync_reg, vsync_next;
    logic              line_start_reg,  line_start_next;
    logic              frame_start_reg, frame_start_next;
    logic [ADDR_W-1:0] addr_reg,  addr_next;
    logic [31:0]       col_ext, row_ext;

    // A pixel step needs both the strobe and enable so a freeze also swallows a pending strobe
    assign advance = pix_ce_int & enable;

    // Next position and everything decoded from it, so outputs line up with col/row
    always_comb begin
        col_next = col_reg + COL_W'(1);
        row_next = row_reg;
        if (col_reg == COL_LAST) begin
            col_next = '0;
            row_next = (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
        end

        col_ext = 32'(col_next);
        row_ext = 32'(row_next);

        de_next          = (col_ext < H_ACTIVE) && (row_ext < V_ACTIVE);
        hsync_next       = ((col_ext >= HS_START) && (col_ext < HS_END)) ? HS_POL : ~HS_POL;
        vsync_next       = ((row_ext >= VS_START) && (row_ext < VS_END)) ? VS_POL : ~VS_POL;
        line_start_next  = (col_next == '0);
        frame_start_next = (col_next == '0) && (row_next == '0);

        // Address steps past each visible pixel as we leave it, restarting at frame origin
        addr_next = addr_reg;
        if (frame_start_next) begin
            addr_next = '0;
        end else if (de_reg) begin
            addr_next = addr_reg + ADDR_W'(1);
        end
    end

    // Position/decode registers update once per pixel; reset parks at the last position
    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg         <= COL_LAST;
            row_reg         <= ROW_LAST;
            de_reg          <= 1'b0;
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            addr_reg        <= '0;
        end else if (advance) begin
            col_reg         <= col_next;
            row_reg         <= row_next;
            de_reg          <= de_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
            addr_reg        <= addr_next;
        end
    end

    assign pix_ce      = pix_ce_int;
    assign col         = col_reg;
    assign row         = row_reg;
    assign de          = de_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign addr        = addr_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: dut 0 uses the 640x480 defaults, dut 1 a tiny 4x3 frame
// with active-high syncs. Expected pixels come from a closed-form position model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct {
        int col; int row; int de; int hs; int vs; int ls; int fs; int addr;
    } px_t;

    typedef struct {
        int pd; int ha; int hfp; int hsy; int hbp;
        int va; int vfp; int vsy; int vbp; int hpol; int vpol;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, en_a = 1'b0;
    logic rst_b = 1'b1, en_b = 1'b0;

    logic        pce_a, de_a, hs_a, vs_a, ls_a, fs_a;
    logic [9:0]  col_a, row_a;
    logic [18:0] addr_a;
    logic        pce_b, de_b, hs_b, vs_b, ls_b, fs_b;
    logic [2:0]  col_b, row_b;
    logic [3:0]  addr_b;

    vga_timing_gen #(
        .PIX_DIV(4), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .HS_POL(1'b0), .VS_POL(1'b0), .COL_W(10), .ROW_W(10), .ADDR_W(19)
    ) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .pix_ce(pce_a), .col(col_a), .row(row_a),
        .de(de_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a), .addr(addr_a)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .COL_W(3), .ROW_W(3), .ADDR_W(4)
    ) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .pix_ce(pce_b), .col(col_b), .row(row_b),
        .de(de_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b), .addr(addr_b)
    );

    int  n_vec = 0;
    int  n_bad = 0;
    px_t q0[$];
    px_t q1[$];
    int  pos[2] = '{0, 0};

    bit  en_e[2]      = '{1'b0, 1'b0};
    bit  rst_e[2]     = '{1'b1, 1'b1};
    bit  pce_prev[2]  = '{1'b0, 1'b0};
    int  gap[2]       = '{0, 0};
    px_t snap[2];

    function automatic cfg_t get_cfg(input int d);
        cfg_t c;
        if (d == 0) c = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
        else        c = '{1, 4, 1, 1, 1, 3, 1, 1, 1, 1, 1};
        return c;
    endfunction

    // Expected outputs for the k-th pixel since frame origin, written from the timing definition
    function automatic px_t model(input int d, input int k);
        cfg_t c;
        px_t  m;
        int   ht, vt, cc, rr;
        c  = get_cfg(d);
        ht = c.ha + c.hfp + c.hsy + c.hbp;
        vt = c.va + c.vfp + c.vsy + c.vbp;
        cc = k % ht;
        rr = (k / ht) % vt;
        m.col  = cc;
        m.row  = rr;
        m.de   = (cc < c.ha && rr < c.va) ? 1 : 0;
        m.hs   = (cc >= c.ha + c.hfp && cc < c.ha + c.hfp + c.hsy) ? c.hpol : 1 - c.hpol;
        m.vs   = (rr >= c.va + c.vfp && rr < c.va + c.vfp + c.vsy) ? c.vpol : 1 - c.vpol;
        m.ls   = (cc == 0) ? 1 : 0;
        m.fs   = (cc == 0 && rr == 0) ? 1 : 0;
        if (rr >= c.va)     m.addr = c.ha * c.va;
        else if (cc < c.ha) m.addr = rr * c.ha + cc;
        else                m.addr = (rr + 1) * c.ha;
        return m;
    endfunction

    function automatic px_t reset_px(input int d);
        cfg_t c;
        px_t  m;
        c = get_cfg(d);
        m.col  = c.ha + c.hfp + c.hsy + c.hbp - 1;
        m.row  = c.va + c.vfp + c.vsy + c.vbp - 1;
        m.de   = 0;
        m.hs   = 1 - c.hpol;
        m.vs   = 1 - c.vpol;
        m.ls   = 0;
        m.fs   = 0;
        m.addr = 0;
        return m;
    endfunction

    function automatic px_t get_obs(input int d);
        px_t o;
        if (d == 0) begin
            o.col = 32'(col_a); o.row = 32'(row_a); o.de = 32'(de_a); o.hs = 32'(hs_a);
            o.vs = 32'(vs_a); o.ls = 32'(ls_a); o.fs = 32'(fs_a); o.addr = 32'(addr_a);
        end else begin
            o.col = 32'(col_b); o.row = 32'(row_b); o.de = 32'(de_b); o.hs = 32'(hs_b);
            o.vs = 32'(vs_b); o.ls = 32'(ls_b); o.fs = 32'(fs_b); o.addr = 32'(addr_b);
        end
        return o;
    endfunction

    function automatic bit px_eq(input px_t g, input px_t e);
        return g.col == e.col && g.row == e.row && g.de == e.de && g.hs == e.hs &&
               g.vs == e.vs && g.ls == e.ls && g.fs == e.fs && g.addr == e.addr;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk_px(input string nm, input int d, input px_t g, input px_t e);
        n_vec++;
        if (!px_eq(g, e)) begin
            n_bad++;
            $display("FAIL %s dut%0d: got col=%0d row=%0d de=%0d hs=%0d vs=%0d ls=%0d fs=%0d addr=%0d, required col=%0d row=%0d de=%0d hs=%0d vs=%0d ls=%0d fs=%0d addr=%0d",
                     nm, d, g.col, g.row, g.de, g.hs, g.vs, g.ls, g.fs, g.addr,
                     e.col, e.row, e.de, e.hs, e.vs, e.ls, e.fs, e.addr);
        end
    endtask

    task automatic chk_int(input string nm, input int d, input int g, input int e);
        n_vec++;
        if (g != e) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d, required %0d", nm, d, g, e);
        end
    endtask

    task automatic chk_pce_low(input string nm, input int d, input logic p);
        n_vec++;
        if (p !== 1'b0) begin
            n_bad++;
            $display("FAIL %s dut%0d: pix_ce got %b, required 0", nm, d, p);
        end
    endtask

    // Capture the inputs each DUT saw at the active edge
    initial begin
        forever begin
            @(posedge clk);
            en_e[0]  = en_a;
            rst_e[0] = rst_a;
            en_e[1]  = en_b;
            rst_e[1] = rst_b;
        end
    end

    // Monitor: on each pixel step pop the scoreboard, otherwise outputs must hold
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                cfg_t c;
                px_t  o, e;
                logic p;
                bit   upd;
                c = get_cfg(d);
                o = get_obs(d);
                p = (d == 0) ? pce_a : pce_b;
                if (rst_e[d]) begin
                    gap[d] = 0;
                    chk_pce_low("pix_ce_in_reset", d, p);
                end else if (en_e[d]) begin
                    gap[d]++;
                    if (p === 1'b1) begin
                        chk_int("pix_ce_gap", d, gap[d], c.pd);
                        gap[d] = 0;
                    end
                end else begin
                    chk_pce_low("pix_ce_disabled", d, p);
                end
                upd = pce_prev[d] && en_e[d] && !rst_e[d];
                if (upd) begin
                    if (qsize(d) == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_step dut%0d: position moved to col=%0d row=%0d, required no step", d, o.col, o.row);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk_px("pixel", d, o, e);
                    end
                end else if (!rst_e[d]) begin
                    chk_px("hold", d, o, snap[d]);
                end
                snap[d]     = o;
                pce_prev[d] = (p === 1'b1);
            end
        end
    end

    // Queue n expected pixels, enable the DUT and wait (bounded) for them to be consumed
    task automatic run_pix(input int d, input int n);
        cfg_t c;
        int   budget;
        bit   done;
        c = get_cfg(d);
        for (int i = 0; i < n; i++) begin
            if (d == 0) q0.push_back(model(d, pos[d]));
            else        q1.push_back(model(d, pos[d]));
            pos[d]++;
        end
        if (d == 0) en_a = 1'b1; else en_b = 1'b1;
        budget = n * c.pd + 20;
        done   = 1'b0;
        for (int t = 0; t < budget && !done; t++) begin
            @(negedge clk);
            #1;
            if (qsize(d) == 0) done = 1'b1;
        end
        if (d == 0) en_a = 1'b0; else en_b = 1'b0;
        chk_int("drain_left", d, qsize(d), 0);
        if (d == 0) q0.delete(); else q1.delete();
        $display("run dut%0d: %0d pixels, next pixel index %0d", d, n, pos[d]);
    endtask

    task automatic chk_reset(input string nm, input int d);
        chk_px(nm, d, get_obs(d), reset_px(d));
        chk_pce_low(nm, d, (d == 0) ? pce_a : pce_b);
    endtask

    initial begin
        int n;
        // Reset held with enable low, then with enable high (reset wins)
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_reset("reset_a", 0);
        chk_reset("reset_b", 1);
        en_a = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_reset("reset_over_enable_a", 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        en_a  = 1'b0;

        // One full line plus the first pixel of row 1, then mid-line freeze and resume
        run_pix(0, 801);
        run_pix(0, 300);
        repeat (10) @(negedge clk);
        #1;
        $display("idle dut0: enable low for 10 clks");
        run_pix(0, 60);

        // Small frame: two full frames and the wrap back to origin
        run_pix(1, 85);

        // Run to (5,2), then reset mid-frame with enable still high
        n = ((19 - (pos[1] % 42) + 42) % 42) + 1;
        run_pix(1, n);
        chk_int("pre_reset_col", 1, 32'(col_b), 5);
        rst_b = 1'b1;
        en_b  = 1'b1;
        @(negedge clk); #1;
        chk_reset("mid_frame_reset_b", 1);
        rst_b = 1'b0;
        en_b  = 1'b0;
        pos[1] = 0;
        run_pix(1, 43);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
